// File: rtl/rx_frame_shift_if.sv
// Receive deserializer handshake bundle: control strobes in, decoded frame out.
interface rx_frame_shift_if #(
  parameter int DATA_BITS = 8
);
  logic                 clr;
  logic                 start;
  logic                 sh;
  logic                 sdi;
  logic [DATA_BITS-1:0] data;
  logic                 frame_valid;
  logic                 parity_err;
  logic                 framing_err;
  logic                 busy;

  modport master (
    output clr, start, sh, sdi,
    input  data, frame_valid, parity_err, framing_err, busy
  );

  modport slave (
    input  clr, start, sh, sdi,
    output data, frame_valid, parity_err, framing_err, busy
  );
endinterface

// File: rtl/rx_frame_shift.sv
// Receive deserializer: collects data, optional parity and stop bits on
// bit-centre strobes and publishes the word with parity/framing status.
//
// state    | meaning
// ST_IDLE  | waiting for a validated start bit, sh ignored
// ST_SHIFT | sampling sdi on each sh until the whole frame is in
module rx_frame_shift #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic          clk,
  input  logic          reset,
  rx_frame_shift_if.slave bus
);
  localparam int FRAME_LEN = DATA_BITS + PARITY_EN + STOP_BITS;
  localparam int CW        = $clog2(FRAME_LEN + 1);

  localparam logic [CW-1:0] CNT_DATA = CW'(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
  localparam logic          PAR_EN   = (PARITY_EN != 0);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);
  localparam logic          MSB      = (MSB_FIRST != 0);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 stop_ok_q, stop_ok_d;
  logic                 parity_err_q, parity_err_d;
  logic                 framing_err_q, framing_err_d;
  logic                 frame_valid_q, frame_valid_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    data_d        = data_q;
    par_d         = par_q;
    stop_ok_d     = stop_ok_q;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    frame_valid_d = 1'b0;

    // Abort drops the partial frame but keeps the last published result.
    if (bus.clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      shreg_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d   = ST_SHIFT;
            cnt_d     = '0;
            shreg_d   = '0;
            par_d     = 1'b0;
            stop_ok_d = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bus.sh) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q < CNT_DATA) begin
              if (MSB) shreg_d = {shreg_q[DATA_BITS-2:0], bus.sdi};
              else     shreg_d = {bus.sdi, shreg_q[DATA_BITS-1:1]};
            end else if (PAR_EN && (cnt_q == CNT_DATA)) begin
              par_d = bus.sdi;
            end else begin
              stop_ok_d = stop_ok_q & bus.sdi;
            end
            // The last sample is always a stop bit, so shreg_d/par_d are final here.
            if (cnt_q == CNT_LAST) begin
              state_d       = ST_IDLE;
              frame_valid_d = 1'b1;
              data_d        = shreg_d;
              parity_err_d  = PAR_EN & (^shreg_d ^ par_d ^ PAR_ODD);
              framing_err_d = ~stop_ok_d;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      shreg_q       <= '0;
      data_q        <= '0;
      par_q         <= 1'b0;
      stop_ok_q     <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      data_q        <= data_d;
      par_q         <= par_d;
      stop_ok_q     <= stop_ok_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign bus.data        = data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.parity_err  = parity_err_q;
  assign bus.framing_err = framing_err_q;
  assign bus.busy        = (state_q == ST_SHIFT);
endmodule

// File: tb/tb_rx_frame_shift.sv
// Four deserializer configurations driven by one shared stimulus stream and
// checked every cycle against a bit-list reference model.
module tb_rx_frame_shift;
  localparam int N_DUT = 4;
  localparam int CFG_D [N_DUT] = '{8, 8, 7, 5};
  localparam int CFG_P [N_DUT] = '{0, 1, 0, 1};
  localparam int CFG_O [N_DUT] = '{0, 0, 0, 1};
  localparam int CFG_S [N_DUT] = '{1, 1, 2, 2};
  localparam int CFG_M [N_DUT] = '{0, 0, 1, 0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clr = 1'b0, start = 1'b0, sh = 1'b0, sdi = 1'b1;

  always #5 clk = ~clk;

  rx_frame_shift_if #(.DATA_BITS(CFG_D[0])) if0 ();
  rx_frame_shift_if #(.DATA_BITS(CFG_D[1])) if1 ();
  rx_frame_shift_if #(.DATA_BITS(CFG_D[2])) if2 ();
  rx_frame_shift_if #(.DATA_BITS(CFG_D[3])) if3 ();

  assign if0.clr = clr; assign if0.start = start; assign if0.sh = sh; assign if0.sdi = sdi;
  assign if1.clr = clr; assign if1.start = start; assign if1.sh = sh; assign if1.sdi = sdi;
  assign if2.clr = clr; assign if2.start = start; assign if2.sh = sh; assign if2.sdi = sdi;
  assign if3.clr = clr; assign if3.start = start; assign if3.sh = sh; assign if3.sdi = sdi;

  rx_frame_shift #(.DATA_BITS(CFG_D[0]), .PARITY_EN(CFG_P[0]), .PARITY_ODD(CFG_O[0]),
                   .STOP_BITS(CFG_S[0]), .MSB_FIRST(CFG_M[0]))
    u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  rx_frame_shift #(.DATA_BITS(CFG_D[1]), .PARITY_EN(CFG_P[1]), .PARITY_ODD(CFG_O[1]),
                   .STOP_BITS(CFG_S[1]), .MSB_FIRST(CFG_M[1]))
    u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  rx_frame_shift #(.DATA_BITS(CFG_D[2]), .PARITY_EN(CFG_P[2]), .PARITY_ODD(CFG_O[2]),
                   .STOP_BITS(CFG_S[2]), .MSB_FIRST(CFG_M[2]))
    u_dut2 (.clk(clk), .reset(reset), .bus(if2));
  rx_frame_shift #(.DATA_BITS(CFG_D[3]), .PARITY_EN(CFG_P[3]), .PARITY_ODD(CFG_O[3]),
                   .STOP_BITS(CFG_S[3]), .MSB_FIRST(CFG_M[3]))
    u_dut3 (.clk(clk), .reset(reset), .bus(if3));

  logic [31:0] o_data [N_DUT];
  logic        o_fv [N_DUT], o_pe [N_DUT], o_fe [N_DUT], o_busy [N_DUT];

  assign o_data[0] = 32'(if0.data); assign o_fv[0] = if0.frame_valid;
  assign o_pe[0] = if0.parity_err;  assign o_fe[0] = if0.framing_err; assign o_busy[0] = if0.busy;
  assign o_data[1] = 32'(if1.data); assign o_fv[1] = if1.frame_valid;
  assign o_pe[1] = if1.parity_err;  assign o_fe[1] = if1.framing_err; assign o_busy[1] = if1.busy;
  assign o_data[2] = 32'(if2.data); assign o_fv[2] = if2.frame_valid;
  assign o_pe[2] = if2.parity_err;  assign o_fe[2] = if2.framing_err; assign o_busy[2] = if2.busy;
  assign o_data[3] = 32'(if3.data); assign o_fv[3] = if3.frame_valid;
  assign o_pe[3] = if3.parity_err;  assign o_fe[3] = if3.framing_err; assign o_busy[3] = if3.busy;

  int n_checks = 0;
  int n_fail = 0;
  int fv_seen [N_DUT];

  // Reference model: list of sampled line bits per configuration, decoded when full.
  bit          m_busy [N_DUT];
  int          m_cnt [N_DUT];
  bit          m_samp [N_DUT][16];
  logic [31:0] m_data [N_DUT];
  bit          m_pe [N_DUT], m_fe [N_DUT], m_fv [N_DUT];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int f, ones;
    bit stop_ok;
    logic [31:0] d;
    f = CFG_D[k] + CFG_P[k] + CFG_S[k];
    m_fv[k] = 1'b0;
    if (reset) begin
      m_busy[k] = 1'b0; m_cnt[k] = 0; m_data[k] = '0; m_pe[k] = 1'b0; m_fe[k] = 1'b0;
    end else if (clr) begin
      m_busy[k] = 1'b0; m_cnt[k] = 0;
    end else if (!m_busy[k]) begin
      if (start) begin m_busy[k] = 1'b1; m_cnt[k] = 0; end
    end else if (sh) begin
      m_samp[k][m_cnt[k]] = sdi;
      m_cnt[k]++;
      if (m_cnt[k] == f) begin
        d = '0; ones = 0;
        for (int i = 0; i < CFG_D[k]; i++) begin
          if (CFG_M[k] != 0) d[CFG_D[k]-1-i] = m_samp[k][i];
          else               d[i] = m_samp[k][i];
          ones += int'(m_samp[k][i]);
        end
        if (CFG_P[k] != 0) ones += int'(m_samp[k][CFG_D[k]]);
        stop_ok = 1'b1;
        for (int i = CFG_D[k] + CFG_P[k]; i < f; i++) stop_ok &= m_samp[k][i];
        m_data[k] = d;
        m_pe[k]   = (CFG_P[k] != 0) && (((ones + CFG_O[k]) % 2) == 1);
        m_fe[k]   = !stop_ok;
        m_busy[k] = 1'b0;
        m_fv[k]   = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < N_DUT; k++) begin
      model_step(k);
      check_eq($sformatf("d%0d_frame_valid", k), 32'(o_fv[k]), 32'(m_fv[k]));
      check_eq($sformatf("d%0d_busy", k), 32'(o_busy[k]), 32'(m_busy[k]));
      check_eq($sformatf("d%0d_data", k), o_data[k], m_data[k]);
      check_eq($sformatf("d%0d_parity_err", k), 32'(o_pe[k]), 32'(m_pe[k]));
      check_eq($sformatf("d%0d_framing_err", k), 32'(o_fe[k]), 32'(m_fe[k]));
      if (o_fv[k]) fv_seen[k]++;
    end
    @(negedge clk);
  endtask

  // bits[i] is the i-th line bit after the start bit; sh strobes have random gaps.
  task automatic send_frame(input logic [15:0] bits, input int n, input int restart_at,
                            input int clr_at, input int rst_at);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin
        sdi = 1'($urandom);
        tick();
      end
      sh = 1'b1; sdi = bits[i]; tick(); sh = 1'b0;
      if (i + 1 == restart_at) begin start = 1'b1; tick(); start = 1'b0; end
      if (i + 1 == clr_at) begin clr = 1'b1; tick(); clr = 1'b0; return; end
      if (i + 1 == rst_at) begin reset = 1'b1; tick(); reset = 1'b0; return; end
    end
    tick();
  endtask

  task automatic resync();
    clr = 1'b1; tick(); clr = 1'b0; tick();
  endtask

  int fv_before;

  initial begin
    for (int k = 0; k < N_DUT; k++) fv_seen[k] = 0;
    @(negedge clk);
    tick(); tick();
    check_eq("rst_busy0", 32'(o_busy[0]), 32'd0);
    check_eq("rst_data0", o_data[0], 32'h0);
    reset = 1'b0;
    tick();

    // 8N1 basic frame
    fv_before = fv_seen[0];
    send_frame(16'h0155, 9, 0, 0, 0);
    check_eq("t1_data", o_data[0], 32'h55);
    check_eq("t1_pe", 32'(o_pe[0]), 32'd0);
    check_eq("t1_fe", 32'(o_fe[0]), 32'd0);
    check_eq("t1_fv_count", 32'(fv_seen[0] - fv_before), 32'd1);
    resync();

    // even parity, bad then good parity bit
    send_frame(16'h0201, 10, 0, 0, 0);
    check_eq("t2a_pe", 32'(o_pe[1]), 32'd1);
    check_eq("t2a_data", o_data[1], 32'h01);
    resync();
    send_frame(16'h0301, 10, 0, 0, 0);
    check_eq("t2b_pe", 32'(o_pe[1]), 32'd0);
    check_eq("t2b_data", o_data[1], 32'h01);
    resync();

    // stop bit low, then clean frame
    send_frame(16'h00A5, 9, 0, 0, 0);
    check_eq("t3a_fe", 32'(o_fe[0]), 32'd1);
    check_eq("t3a_data", o_data[0], 32'hA5);
    resync();
    send_frame(16'h01A5, 9, 0, 0, 0);
    check_eq("t3b_fe", 32'(o_fe[0]), 32'd0);
    resync();

    // start during SHIFT is ignored
    fv_before = fv_seen[0];
    send_frame(16'h013C, 9, 4, 0, 0);
    check_eq("t4_data", o_data[0], 32'h3C);
    check_eq("t4_fv_count", 32'(fv_seen[0] - fv_before), 32'd1);
    resync();

    // reset after 3rd sh, then clean frame
    fv_before = fv_seen[0];
    send_frame(16'h01C3, 9, 0, 0, 3);
    check_eq("t5a_busy", 32'(o_busy[0]), 32'd0);
    check_eq("t5a_fv_count", 32'(fv_seen[0] - fv_before), 32'd0);
    tick();
    send_frame(16'h01C3, 9, 0, 0, 0);
    check_eq("t5b_data", o_data[0], 32'hC3);
    resync();

    // clr after 5th sh keeps last data, then clean frame
    fv_before = fv_seen[0];
    send_frame(16'h017E, 9, 0, 5, 0);
    check_eq("t5c_busy", 32'(o_busy[0]), 32'd0);
    check_eq("t5c_fv_count", 32'(fv_seen[0] - fv_before), 32'd0);
    check_eq("t5c_data_kept", o_data[0], 32'hC3);
    tick();
    send_frame(16'h017E, 9, 0, 0, 0);
    check_eq("t5d_data", o_data[0], 32'h7E);
    resync();

    // MSB first, 7 data bits, 2 stop bits
    send_frame(16'h01C1, 9, 0, 0, 0);
    check_eq("t6a_data", o_data[2], 32'h41);
    check_eq("t6a_fe", 32'(o_fe[2]), 32'd0);
    resync();
    send_frame(16'h00C1, 9, 0, 0, 0);
    check_eq("t6b_fe", 32'(o_fe[2]), 32'd1);
    check_eq("t6b_data", o_data[2], 32'h41);
    resync();

    // random traffic: arbitrary strobe spacing, overlapping start/sh, aborts, resets
    for (int c = 0; c < 5000; c++) begin
      start = ($urandom_range(0, 5) == 0);
      sh    = ($urandom_range(0, 2) == 0);
      sdi   = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 799) == 0);
      tick();
    end
    start = 1'b0; sh = 1'b0; clr = 1'b0; reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
